uart_frame_accumulator: RTL
===========================

UART_FRAME_ACCUMULATOR -- requirements
Module: uart_frame_accumulator

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 128: payload capacity in bytes, range 1..255.
REQ-002 SHALL have parameter TIMEOUT, default 2000: idle clk cycles allowed between bytes inside a frame.
REQ-003 SHALL have parameter SZ_W, default 8: width of frame_size; must satisfy 2^SZ_W > MAX_BYTES.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port: clk  input  1  rising-edge clock for all state.
REQ-006 Port: reset_n  input  1  asynchronous active-low reset.
REQ-007 Port: soft_reset  input  1  synchronous abort/clear, active-high.
REQ-008 Port: mode  input  1  terminator select: 0 = two-byte 0xBE 0xEF trailer, 1 = single 0x0D (BLE side).
REQ-009 Port: in_data  input  8  received UART byte.
REQ-010 Port: in_valid  input  1  in_data valid this cycle; a byte is accepted when in_valid && in_ready.
REQ-011 Port: in_ready  output  1  block can accept a byte.
REQ-012 Port: frame_data  output  MAX_BYTES*8  payload; byte k is at [8k+7:8k].
REQ-013 Port: frame_size  output  SZ_W  payload byte count of the presented frame.
REQ-014 Port: frame_valid  output  1  frame presented; held until frame_ready.
REQ-015 Port: frame_ready  input  1  consumer accepts the frame when frame_valid && frame_ready.
REQ-016 Port: error  output  1  one-cycle pulse on frame abort.
REQ-017 Port: error_code  output  2  cause of last abort: 0 none, 1 overflow, 2 timeout, 3 bad trailer.

Function
REQ-018 SHALL implement a fully synchronous FSM with states IDLE, ACCUM, TRAIL and HOLD; all registers update on the rising edge of clk only.
REQ-019 in_ready SHALL be 1 in IDLE, ACCUM and TRAIL, and 0 in HOLD.
REQ-020 In IDLE, an accepted byte SHALL start a frame: latch mode, clear frame_data and byte count, clear error_code, and then process the byte exactly as in ACCUM, all in the same cycle.
REQ-021 In ACCUM, an accepted terminator (0x0D if latched mode=1; 0xBE if latched mode=0) SHALL NOT be stored; mode=1 goes to HOLD, mode=0 goes to TRAIL.
REQ-022 In ACCUM, an accepted non-terminator byte with count < MAX_BYTES SHALL be written to byte slot [count], with count incremented.
REQ-023 In ACCUM, an accepted non-terminator byte with count == MAX_BYTES SHALL pulse error, set error_code=1 and go to IDLE.
REQ-024 In TRAIL, an accepted 0xEF SHALL go to HOLD; any other accepted byte SHALL pulse error, set error_code=3 and go to IDLE.
REQ-025 A terminator completing a frame with count == 0 SHALL drop the frame silently and return to IDLE, with no frame_valid and no error.
REQ-026 Entering HOLD SHALL set frame_valid=1 and frame_size=count on the next cycle; frame_data is stable while frame_valid=1 and slots at index >= frame_size are zero.
REQ-027 In HOLD, frame_valid && frame_ready SHALL clear frame_valid and go to IDLE in the same edge.
REQ-028 Mode changes after frame start SHALL have no effect until the next frame.
REQ-029 The timeout counter SHALL clear on every accepted byte and increment each cycle in ACCUM or TRAIL without an accepted byte.
REQ-030 When the timeout counter reaches TIMEOUT, the block SHALL pulse error, set error_code=2 and go to IDLE; a byte accepted on that same cycle wins and clears the counter.
REQ-031 The timeout counter SHALL hold at 0 in IDLE and HOLD.
REQ-032 soft_reset SHALL have priority over all events: next state IDLE, frame_valid=0, frame_size=0, count=0, error=0, error_code=0, timeout counter=0; frame_data is unchanged.
REQ-033 error_code SHALL hold its value until the next frame start or any reset.

Reset
REQ-034 reset_n=0 SHALL immediately force IDLE, frame_data=0, frame_size=0, frame_valid=0, error=0, error_code=0, count=0, timeout counter=0, latched mode=0.
REQ-035 in_ready SHALL be 1 during and after reset.

Verification
REQ-036 mode=1, bytes 0x41 0x42 0x0D -> one cycle later frame_valid=1, frame_size=2, frame_data[15:0]=0x4241, upper bits 0; frame_ready=1 -> IDLE.
REQ-037 mode=0, bytes 0x01 0xBE 0x02 -> error pulse, error_code=3, no frame_valid; then 0x05 0xBE 0xEF -> frame_size=1, error_code=0.
REQ-038 MAX_BYTES=4, mode=1, five non-0x0D bytes -> error on 5th byte, error_code=1; next byte starts a new frame.
REQ-039 TIMEOUT=10, one byte then in_valid=0 for 10 cycles -> error, error_code=2; a byte on the 10th idle cycle instead keeps the frame alive.
REQ-040 Frame in HOLD with frame_ready=0 for 50 cycles -> in_ready=0, frame stable, no timeout; soft_reset mid-ACCUM -> IDLE, no error; reset_n low mid-frame -> all outputs at reset values.

Source files
------------

// File: rtl/uart_frame_accumulator.sv
// Collects UART bytes into a frame up to a mode-selected terminator, then presents
// the payload until the consumer takes it. Overflow, idle timeout and a bad trailer abort the frame.
module uart_frame_accumulator #(
  parameter int unsigned MAX_BYTES = 128,
  parameter int unsigned TIMEOUT   = 2000,
  parameter int unsigned SZ_W      = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   soft_reset,
  input  logic                   mode,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [MAX_BYTES*8-1:0] frame_data,
  output logic [SZ_W-1:0]        frame_size,
  output logic                   frame_valid,
  input  logic                   frame_ready,
  output logic                   error,
  output logic [1:0]             error_code
);

  localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);
  localparam logic [7:0]  TERM_CR = 8'h0D;
  localparam logic [7:0]  TERM_HI = 8'hBE;
  localparam logic [7:0]  TERM_LO = 8'hEF;

  typedef enum logic [1:0] {IDLE, ACCUM, TRAIL, HOLD} state_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_OVF, ERR_TMO, ERR_TRAIL} err_code_e;

  state_e                   state_q, state_d;
  err_code_e                code_q, code_d;
  logic                     mode_q, mode_d, mode_eff;
  logic [SZ_W-1:0]          cnt_q, cnt_d, cnt_eff;
  logic [TMO_W-1:0]         tmo_q, tmo_d;
  logic [MAX_BYTES*8-1:0]   data_d;
  logic [SZ_W-1:0]          size_d;
  logic                     valid_d, err_d, accept;

  assign in_ready   = (state_q != HOLD);
  assign accept     = in_valid && in_ready;
  assign error_code = code_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      code_q      <= ERR_NONE;
      mode_q      <= 1'b0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      frame_data  <= '0;
      frame_size  <= '0;
      frame_valid <= 1'b0;
      error       <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      frame_data  <= data_d;
      frame_size  <= size_d;
      frame_valid <= valid_d;
      error       <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    code_d   = code_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    data_d   = frame_data;
    size_d   = frame_size;
    valid_d  = frame_valid;
    err_d    = 1'b0;
    mode_eff = mode_q;
    cnt_eff  = cnt_q;

    if (soft_reset) begin
      state_d = IDLE;
      valid_d = 1'b0;
      size_d  = '0;
      cnt_d   = '0;
      tmo_d   = '0;
      code_d  = ERR_NONE;
    end else if (state_q == HOLD) begin
      tmo_d = '0;
      if (frame_valid && frame_ready) begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    end else if (accept) begin
      tmo_d = '0;
      // A frame-starting byte sees the freshly cleared context, then falls into ACCUM handling.
      if (state_q == IDLE) begin
        mode_d   = mode;
        mode_eff = mode;
        cnt_d    = '0;
        cnt_eff  = '0;
        data_d   = '0;
        code_d   = ERR_NONE;
      end
      if (state_q == TRAIL) begin
        if (in_data != TERM_LO) begin
          err_d   = 1'b1;
          code_d  = ERR_TRAIL;
          state_d = IDLE;
        end else if (cnt_eff == '0) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
          valid_d = 1'b1;
          size_d  = cnt_eff;
        end
      end else if (in_data == (mode_eff ? TERM_CR : TERM_HI)) begin
        if (!mode_eff) begin
          state_d = TRAIL;
        end else if (cnt_eff == '0) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
          valid_d = 1'b1;
          size_d  = cnt_eff;
        end
      end else if (cnt_eff == SZ_W'(MAX_BYTES)) begin
        err_d   = 1'b1;
        code_d  = ERR_OVF;
        state_d = IDLE;
      end else begin
        for (int unsigned k = 0; k < MAX_BYTES; k++) begin
          if (SZ_W'(k) == cnt_eff) data_d[8*k +: 8] = in_data;
        end
        cnt_d   = cnt_eff + SZ_W'(1);
        state_d = ACCUM;
      end
    end else if (state_q != IDLE) begin
      // Abort on the cycle whose increment would reach TIMEOUT; an accepted byte above takes precedence.
      if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
        tmo_d   = '0;
        err_d   = 1'b1;
        code_d  = ERR_TMO;
        state_d = IDLE;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

endmodule
